fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 97 +++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction buffer: circular FIFO of {pc, instr} pairs with flush.
// Define FETCH_BUF_BYPASS_EN to let an empty buffer forward the incoming pair combinationally.
module fetch_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_pc,
    input  logic [DATA_WIDTH-1:0]       in_instr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_pc,
    output logic [DATA_WIDTH-1:0]       out_instr,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]         FULL = CW'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(32'h00000013);

    logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         occ;

    logic stored_valid;
    logic bypass_valid;
    logic push;
    logic pop;

    // Handshake: a transfer happens on a rising edge only when valid and ready are
    // both high; ready never depends on the opposite side's ready in the same cycle.
    assign stored_valid = (occ != '0);
    assign in_ready     = (occ < FULL);
    assign count        = occ;

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass_valid = !stored_valid && in_valid && !flush;
`else
    assign bypass_valid = 1'b0;
`endif

    assign out_valid = stored_valid || bypass_valid;

    // A bypassed pair that decode takes immediately never occupies an entry.
    assign push = in_valid && in_ready && !(bypass_valid && out_ready);
    assign pop  = stored_valid && out_ready;

    always_comb begin
        out_pc    = '0;
        out_instr = NOP;
        if (stored_valid) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end else if (bypass_valid) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= NOP;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= in_pc;
                instr_mem[wr_ptr] <= in_instr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule
